// File: rtl/ulbf_coeffs_pkg.sv
// Shared types and default widths for the coefficient read scheduler.
// Holds the scheduler state encoding and the DATA_W/ADDR_W/CNT_W defaults.
package ulbf_coeffs_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ulbf_coeffs_rd_sched_if.sv
// AXI4-Stream bundle between the coefficient scheduler and its consumer.
// master: drives tdata/tvalid/tlast, samples tready; slave: the reverse.
interface ulbf_coeffs_rd_sched_if #(
  parameter int DATA_W = ulbf_coeffs_pkg::DATA_W
) ();

  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/ulbf_coeffs_skid_fifo.sv
// Two-entry output FIFO; head entry drives the stream, stable until popped.
// Ports: i_in_* / o_in_ready write side, o_out_* / i_out_ready read side, o_count occupancy.
module ulbf_coeffs_skid_fifo #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_out_valid = (r_cnt != 2'd0);
  assign o_in_ready  = (r_cnt != 2'd2) | i_out_ready;
  assign o_out_data  = r_d0;
  assign o_count     = r_cnt;
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_d0 <= r_d1;
            r_d1 <= i_in_data;
          end else begin
            r_d0 <= i_in_data;
          end
        end
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_in_data;
          else               r_d1 <= i_in_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ulbf_coeffs_rd_sched.sv
// Reads block_size*niter coefficient rows from BRAM port B and streams them out.
// Ports: go/sizes in, enb/addrb/doutb to BRAM, axis stream master, done status.
module ulbf_coeffs_rd_sched
  import ulbf_coeffs_pkg::*;
#(
  parameter int DATA_W = ulbf_coeffs_pkg::DATA_W,
  parameter int ADDR_W = ulbf_coeffs_pkg::ADDR_W,
  parameter int CNT_W  = ulbf_coeffs_pkg::CNT_W
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_rst,
  input  logic              go,
  input  logic [CNT_W-1:0]  block_size,
  input  logic [CNT_W-1:0]  niter,
  input  logic [ADDR_W-1:0] rollover_addr,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  ulbf_coeffs_rd_sched_if.master axis,
  output logic              done
);

  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            r_state;
  logic              r_go;
  logic              r_dv;
  logic              r_dlast;
  logic [CNT_W-1:0]  r_bs;
  logic [CNT_W-1:0]  r_nit;
  logic [CNT_W-1:0]  r_beat;
  logic [CNT_W-1:0]  r_blk;
  logic [ADDR_W-1:0] r_roll;
  logic [ADDR_W-1:0] r_addr;

  logic              w_start;
  logic              w_zero;
  logic              w_pop;
  logic              w_can;
  logic              w_issue;
  logic              w_lbeat;
  logic              w_lblk;
  logic              w_in_rdy;
  logic [1:0]        w_occ;
  logic [2:0]        w_load;
  logic [DATA_W:0]   w_head;
  logic [CNT_W-1:0]  w_bs;
  logic [CNT_W-1:0]  w_nit;
  logic [CNT_W-1:0]  w_beat;
  logic [CNT_W-1:0]  w_blk;
  logic [ADDR_W-1:0] w_roll;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_start = ~m_axis_rst & go & ~r_go &
                   ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_zero  = (block_size == '0) | (niter == '0);

  // The first read goes out in the start cycle itself, so it
  // uses the live inputs and zeroed counters, not the latched copies.
  assign w_bs   = w_start ? block_size    : r_bs;
  assign w_nit  = w_start ? niter         : r_nit;
  assign w_roll = w_start ? rollover_addr : r_roll;
  assign w_beat = w_start ? '0            : r_beat;
  assign w_blk  = w_start ? '0            : r_blk;
  assign w_addr = w_start ? '0            : r_addr;

  // Slot accounting: a beat popped this cycle frees its slot.
  assign w_pop  = axis.m_axis_tvalid & axis.m_axis_tready;
  assign w_load = {1'b0, w_occ} + {2'b0, r_dv} - {2'b0, w_pop};
  assign w_can  = w_in_rdy & (w_load < 3'd2);

  assign w_issue = ~m_axis_rst & w_can &
                   ((w_start & ~w_zero) | (r_state == ST_RUN));

  assign w_lbeat = (w_beat == w_bs - C_ONE);
  assign w_lblk  = (w_blk == w_nit - C_ONE);

  // rollover 0 gives all-ones here, i.e. natural wrap.
  assign w_addr_nxt = (w_addr == w_roll - A_ONE) ? '0 : w_addr + A_ONE;

  assign enb   = w_issue;
  assign addrb = w_addr;
  assign done  = (r_state == ST_DONE);

  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) begin
      r_state <= ST_IDLE;
      r_go    <= 1'b1;
      r_dv    <= 1'b0;
      r_dlast <= 1'b0;
      r_bs    <= '0;
      r_nit   <= '0;
      r_beat  <= '0;
      r_blk   <= '0;
      r_roll  <= '0;
      r_addr  <= '0;
    end else begin
      r_go    <= go;
      r_dv    <= w_issue;
      r_dlast <= w_lbeat;
      if (w_start) begin
        r_bs    <= block_size;
        r_nit   <= niter;
        r_roll  <= rollover_addr;
        r_beat  <= '0;
        r_blk   <= '0;
        r_addr  <= '0;
        r_state <= w_zero ? ST_DONE : ST_RUN;
      end else if (r_state == ST_DRAIN && w_occ == 2'd0 && !r_dv) begin
        r_state <= ST_DONE;
      end
      if (w_issue) begin
        r_addr <= w_addr_nxt;
        r_beat <= w_lbeat ? '0 : w_beat + C_ONE;
        if (w_lbeat) r_blk <= w_blk + C_ONE;
        if (w_lbeat && w_lblk) r_state <= ST_DRAIN;
      end
    end
  end

  ulbf_coeffs_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .i_clk       (m_axis_clk),
    .i_rst       (m_axis_rst),
    .i_in_valid  (r_dv),
    .o_in_ready  (w_in_rdy),
    .i_in_data   ({r_dlast, doutb}),
    .o_out_valid (axis.m_axis_tvalid),
    .i_out_ready (axis.m_axis_tready),
    .o_out_data  (w_head),
    .o_count     (w_occ)
  );

  assign axis.m_axis_tdata = w_head[DATA_W-1:0];
  assign axis.m_axis_tlast = w_head[DATA_W];

endmodule
